// File: rtl/irq_arbiter_if.sv
// irq_arbiter_if: interrupt sources, CSR controls and grant outputs of the IRQ arbiter
interface irq_arbiter_if;
    logic [3:0] src_i;
    logic [3:0] en_i;
    logic [3:0] clear_i;
    logic       ack_i;
    logic [3:0] irq_o;
    logic [3:0] pending_o;
    logic       busy_o;
    modport master (output src_i, en_i, clear_i, ack_i, input irq_o, pending_o, busy_o);
    modport slave  (input src_i, en_i, clear_i, ack_i, output irq_o, pending_o, busy_o);
endinterface

// File: rtl/irq_arbiter.sv
// irq_arbiter: edge-latched pending bits, fixed-priority non-preemptive grant with post-ack holdoff
module irq_arbiter #(
    parameter int HOLDOFF = 4
) (
    input logic         clk,
    input logic         rstn,
    irq_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HOLDOFF} state_t;
    state_t     state;
    logic [3:0] s1, s2, s3, pending, irq_q, cnt;
    logic       busy_q;
    logic [3:0] rise, cand, pick, ack_mask, pend_nx;
    logic       withdraw;
    assign rise     = s2 & ~s3;
    assign cand     = pending & bus.en_i;
    assign pick     = cand[3] ? 4'b1000 : cand[2] ? 4'b0100 : cand[1] ? 4'b0010 : cand[0] ? 4'b0001 : 4'b0000;
    assign ack_mask = (state == S_GRANT && bus.ack_i) ? irq_q : 4'b0000;
    // new edge beats clear, clear beats ack
    assign pend_nx  = rise | (pending & ~bus.clear_i & ~ack_mask);
    assign withdraw = ~|(irq_q & bus.en_i & ~bus.clear_i & pending);
    always_ff @(posedge clk) begin
        if (!rstn) begin
            {s1, s2, s3, pending, irq_q, cnt} <= '0;
            busy_q <= 1'b0;
            state  <= S_IDLE;
        end else begin
            s1      <= bus.src_i;
            s2      <= s1;
            s3      <= s2;
            pending <= pend_nx;
            case (state)
                S_IDLE: if (|cand) begin
                    state  <= S_GRANT;
                    irq_q  <= pick;
                    busy_q <= 1'b1;
                end
                S_GRANT: if (bus.ack_i) begin
                    irq_q <= 4'b0000;
                    cnt   <= 4'(HOLDOFF - 1);
                    state <= S_HOLDOFF;
                end else if (withdraw) begin
                    irq_q  <= 4'b0000;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                S_HOLDOFF: if (cnt == 4'd0) begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end else cnt <= cnt - 4'd1;
                default: state <= S_IDLE;
            endcase
        end
    end
    assign bus.irq_o     = irq_q;
    assign bus.pending_o = pending;
    assign bus.busy_o    = busy_q;
endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed scenarios plus random traffic, scoreboarded against a cycle model
module tb_irq_arbiter;
    localparam int HOLDOFF = 4;
    typedef struct {
        logic [3:0] irq;
        logic [3:0] pend;
        logic       busy;
    } exp_t;
    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t x;
    logic [3:0] smp [3];
    logic [3:0] m_pend;
    int         g, quiet;
    irq_arbiter_if bus();
    irq_arbiter #(.HOLDOFF(HOLDOFF)) dut (.clk(clk), .rstn(rstn), .bus(bus));
    always #5 clk = ~clk;
    // reference: smp holds the last three samples of src, g the granted source index (-1 none),
    // quiet the number of further edges during which no grant may be issued after an ack
    task automatic step();
        logic [3:0] e;
        int g_old;
        if (!rstn) begin
            foreach (smp[i]) smp[i] = 4'b0;
            m_pend = 4'b0;
            g      = -1;
            quiet  = 0;
        end else begin
            e     = smp[1] & ~smp[2];
            g_old = g;
            if (g >= 0) begin
                if (bus.ack_i) begin
                    quiet = HOLDOFF;
                    g     = -1;
                end else if (!bus.en_i[g] || bus.clear_i[g] || !m_pend[g]) g = -1;
            end else if (quiet > 0) quiet--;
            else for (int i = 0; i < 4; i++) if (m_pend[i] && bus.en_i[i]) g = i;
            for (int i = 0; i < 4; i++)
                m_pend[i] = e[i] ? 1'b1 : bus.clear_i[i] ? 1'b0 : (bus.ack_i && i == g_old) ? 1'b0 : m_pend[i];
            smp[2] = smp[1];
            smp[1] = smp[0];
            smp[0] = bus.src_i;
        end
        q.push_back('{(g >= 0) ? 4'(1 << g) : 4'b0000, m_pend, (g >= 0) || (quiet > 0)});
    endtask
    task automatic cyc(input logic [3:0] s, input logic [3:0] e, input logic [3:0] c, input logic a);
        bus.src_i   = s;
        bus.en_i    = e;
        bus.clear_i = c;
        bus.ack_i   = a;
        step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string n, input logic [3:0] act, input logic [3:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b", n, $time, act, req);
        end
    endtask
    always @(negedge clk) begin
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("irq", bus.irq_o, x.irq);
            chk("pending", bus.pending_o, x.pend);
            chk("busy", {3'b0, bus.busy_o}, {3'b0, x.busy});
            chk("onehot", {3'b0, $onehot0(bus.irq_o)}, 4'b0001);
        end
    end
    initial begin
        logic [3:0] en;
        rstn = 1'b0;
        repeat (2) cyc(4'hF, 4'hF, 4'h0, 1'b0);
        rstn = 1'b1;
        repeat (6) cyc(4'hF, 4'hF, 4'h0, 1'b0);
        cyc(4'h0, 4'hF, 4'h0, 1'b1);
        repeat (7) cyc(4'h0, 4'hF, 4'h0, 1'b0);
        cyc(4'h0, 4'hF, 4'hF, 1'b0);
        repeat (3) cyc(4'h0, 4'hF, 4'h0, 1'b0);
        cyc(4'h2, 4'hF, 4'h0, 1'b0);
        repeat (6) cyc(4'h0, 4'hF, 4'h0, 1'b0);
        cyc(4'h0, 4'hF, 4'h0, 1'b1);
        repeat (7) cyc(4'h0, 4'hF, 4'h0, 1'b0);
        cyc(4'h5, 4'hF, 4'h0, 1'b0);
        repeat (4) cyc(4'h0, 4'hF, 4'h0, 1'b0);
        cyc(4'h8, 4'hF, 4'h0, 1'b0);
        repeat (4) cyc(4'h0, 4'hF, 4'h0, 1'b0);
        repeat (2) begin
            cyc(4'h0, 4'hF, 4'h0, 1'b1);
            repeat (7) cyc(4'h0, 4'hF, 4'h0, 1'b0);
        end
        cyc(4'h0, 4'hF, 4'h0, 1'b1);
        repeat (7) cyc(4'h0, 4'hF, 4'h0, 1'b0);
        cyc(4'h2, 4'hD, 4'h0, 1'b0);
        repeat (8) cyc(4'h0, 4'hD, 4'h0, 1'b0);
        repeat (3) cyc(4'h0, 4'hF, 4'h0, 1'b0);
        cyc(4'h0, 4'hF, 4'h0, 1'b1);
        repeat (7) cyc(4'h0, 4'hF, 4'h0, 1'b0);
        cyc(4'h1, 4'hF, 4'h0, 1'b0);
        repeat (5) cyc(4'h0, 4'hF, 4'h0, 1'b0);
        cyc(4'h0, 4'hF, 4'h1, 1'b0);
        repeat (4) cyc(4'h0, 4'hF, 4'h0, 1'b0);
        cyc(4'h2, 4'hF, 4'h0, 1'b0);
        repeat (5) cyc(4'h0, 4'hF, 4'h0, 1'b0);
        cyc(4'h2, 4'hF, 4'h0, 1'b0);
        cyc(4'h0, 4'hF, 4'h0, 1'b0);
        cyc(4'h0, 4'hF, 4'h0, 1'b1);
        repeat (8) cyc(4'h0, 4'hF, 4'h0, 1'b0);
        cyc(4'h0, 4'hF, 4'h0, 1'b1);
        repeat (7) cyc(4'h0, 4'hF, 4'h0, 1'b0);
        cyc(4'h4, 4'hF, 4'h0, 1'b0);
        repeat (5) cyc(4'h4, 4'hF, 4'h0, 1'b0);
        rstn = 1'b0;
        cyc(4'h4, 4'hF, 4'h0, 1'b0);
        rstn = 1'b1;
        repeat (6) cyc(4'h4, 4'hF, 4'h0, 1'b0);
        cyc(4'h0, 4'hF, 4'h4, 1'b0);
        en = 4'hF;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) en = 4'($urandom);
            rstn = ($urandom_range(0, 499) != 0);
            cyc(($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0, en,
                ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'h0, $urandom_range(0, 3) == 0);
        end
        rstn = 1'b1;
        repeat (2) cyc(4'h0, 4'hF, 4'h0, 1'b0);
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 Parameter HOLDOFF, default 4, number of idle cycles after ack_i before the next grant; legal range 1..15.
REQ-002 clk  in  1  core clock; all state updates on the rising edge.
REQ-003 rstn  in  1  reset; synchronous, active-low.
REQ-004 src_i  in  4  raw interrupt sources, asynchronous to clk: bit0 software, bit1 timer, bit2 external, bit3 debug.
REQ-005 en_i  in  4  per-source enable mask, synchronous to clk.
REQ-006 clear_i  in  4  per-source pending clear (CSR write path), synchronous, level-sampled each cycle.
REQ-007 ack_i  in  1  one-cycle pulse from the commit unit when the granted interrupt is taken.
REQ-008 irq_o  out  4  registered one-hot grant, same bit mapping as src_i; drives the commit unit's irq input.
REQ-009 pending_o  out  4  registered pending bits.
REQ-010 busy_o  out  1  high in GRANT or HOLDOFF state.

Function
REQ-011 Each src_i bit SHALL pass through a 2-flop synchronizer (s1, s2) followed by a third flop s3; a rising edge is detected when s2=1 and s3=0.
REQ-012 A detected edge SHALL set the matching pending bit on the next clock edge, regardless of en_i.
REQ-013 Pending-bit update priority, highest first: new detected edge (set) > clear_i (clear) > ack_i for the granted source (clear).
REQ-014 A held-high src_i SHALL produce exactly one pending set; a new set requires src_i to go low for at least 2 cycles and then rise again.
REQ-015 The state machine SHALL have three states: IDLE, GRANT, HOLDOFF.
REQ-016 In IDLE, if (pending & en_i) != 0, the FSM SHALL move to GRANT and register irq_o with the highest-priority candidate, fixed priority debug(3) > external(2) > timer(1) > software(0); otherwise it stays in IDLE with irq_o=0.
REQ-017 In GRANT, irq_o SHALL hold its value; the grant is non-preemptive, so a later higher-priority pending bit does not change irq_o.
REQ-018 In GRANT with ack_i=1: clear the granted pending bit (subject to REQ-013), irq_o<=0, load the holdoff counter with HOLDOFF-1, and go to HOLDOFF.
REQ-019 In GRANT with ack_i=0, if the granted bit has en_i=0 or clear_i=1 or pending=0: irq_o<=0 and go to IDLE, leaving other pending bits unchanged (withdrawn grant, no holdoff).
REQ-020 In HOLDOFF, irq_o SHALL be 0 and the counter decrements each cycle; when the counter is 0, go to IDLE; irq_o is therefore 0 for exactly HOLDOFF+1 cycles after the ack edge.
REQ-021 ack_i outside GRANT SHALL be ignored.
REQ-022 irq_o SHALL always be 4'b0000 or exactly one bit set.
REQ-023 Latency: counting the first edge that samples src_i high as edge 1, pending_o rises after edge 3 and irq_o after edge 4, when in IDLE with en set.
REQ-024 pending_o and busy_o SHALL be registered copies of the internal pending and state, with no combinational path from inputs.

Reset
REQ-025 When rstn=0 at a clock edge, the following are forced to 0: s1, s2, s3, pending, irq_o, pending_o, busy_o and the holdoff counter; state goes to IDLE.
REQ-026 Reset asserted mid-GRANT or mid-HOLDOFF SHALL abort it with no ack required; a src_i held high across reset release SHALL register as a new edge.

Verification
REQ-027 Reset: rstn=0 for 2 cycles with src_i=4'hF -> irq_o=0, pending_o=0, busy_o=0; after release with src_i still 4'hF -> irq_o=4'b1000 after edge 4.
REQ-028 Single event: en_i=4'hF, 1-cycle pulse src_i=4'b0010 -> pending_o=4'b0010 after edge 3, irq_o=4'b0010 after edge 4 and held; ack_i pulse -> pending_o=0, irq_o=0 for 5 cycles (HOLDOFF=4), busy_o low afterwards.
REQ-029 Priority/non-preemption: src_i=4'b0101 together -> irq_o=4'b0100; debug pulse during GRANT -> irq_o stays 4'b0100; ack_i -> after holdoff irq_o=4'b1000, ack_i -> after holdoff irq_o=4'b0001.
REQ-030 Mask: en_i=4'b1101, timer pulse -> pending_o=4'b0010, irq_o=0 indefinitely; set en_i=4'hF -> irq_o=4'b0010 one cycle later.
REQ-031 Withdraw: grant 4'b0001 active, then clear_i=4'b0001 for one cycle -> irq_o=0, pending_o=0, state IDLE, no holdoff.
REQ-032 Collision: timer new edge detected in the same cycle as ack_i of the timer grant -> pending_o stays 4'b0010, and irq_o=4'b0010 reasserts after holdoff.
